level_meter: RTL and testbench
==============================

LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameter WIN_LOG2, default 9, gives a window of 2^WIN_LOG2 accepted samples (512 samples is about 86 Hz at 44100 Hz).
REQ-002 Parameter DECAY_EN, default 1; when 1, the reported level falls by at most 1 code per window (bar-graph release).
REQ-003 Port dclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port sample_valid, input, 1 bit: sample qualifier, one sample accepted per high cycle.
REQ-006 Port sample, input, 12 bits: unsigned ADC code, midscale 12'h800 equals zero signal.
REQ-007 Port level, output, 6 bits: registered window magnitude, feeds the bar-graph driver's 6-bit magnitude input directly.
REQ-008 Port level_valid, output, 1 bit: one-cycle pulse marking a new level value.

Function
REQ-009 Magnitude SHALL be |sample - 2048| computed at 12-bit signed width, giving a range of 0..2048.
REQ-010 A magnitude of 2048 (sample 12'h000) SHALL saturate to 2047, so magnitude is 11 bits.
REQ-011 A window counter (WIN_LOG2 bits) SHALL increment only on cycles with sample_valid=1 and SHALL wrap from 2^WIN_LOG2-1 to 0.
REQ-012 A peak register (11 bits) SHALL hold the maximum magnitude of accepted samples in the current window.
REQ-013 A sample accepted while the counter is at 2^WIN_LOG2-1 (the last sample) SHALL be included in the closing window.
REQ-014 On acceptance of the last sample, the closing peak SHALL be max(peak, current magnitude), and cand SHALL be its bits [10:5].
REQ-015 With DECAY_EN=0, level SHALL load cand on the cycle after the last sample is accepted.
REQ-016 With DECAY_EN=1, level SHALL load max(cand, level-1), with level-1 floored at 0.
REQ-017 level_valid SHALL be 1 for exactly the one cycle in which level takes its new value, and 0 otherwise.
REQ-018 The peak SHALL clear to 0 at the window close, so the next window starts empty.
REQ-019 Cycles with sample_valid=0 SHALL leave the counter, peak, level and level_valid=0 unchanged.
REQ-020 level SHALL hold its value between updates.
REQ-021 Latency from acceptance of the last sample to level_valid SHALL be 1 dclk cycle.
REQ-022 Back-to-back sample_valid on every cycle SHALL be supported with no stall.

Reset
REQ-023 While rst=1 at the dclk edge, the counter, peak and level SHALL be 0, and level_valid SHALL be 0.
REQ-024 rst SHALL take priority over sample_valid; a sample presented during reset is discarded.
REQ-025 Reset asserted mid-window SHALL discard the partial window, and no level_valid pulse SHALL follow.
REQ-026 The first window after reset release SHALL start at count 0.

Structure
REQ-027 Package adc_pkg SHALL hold ADC_W=12, MAG_W=11, LEVEL_W=6, MIDSCALE=12'h800 and MAG_MAX=11'd2047.
REQ-028 Sub-module level_mag SHALL contain only the combinational offset/abs/saturate path (sample -> 11-bit magnitude).
REQ-029 The counter, peak, decay and output registers SHALL reside in level_meter.

Verification (WIN_LOG2=3 on the bench for speed, plus one run at the default)
REQ-030 Feed 8 samples of 12'h800 -> level=0, level_valid pulses once, 1 cycle after the 8th sample.
REQ-031 Feed one sample of 12'h000 among midscale samples, DECAY_EN=0 -> level=63, then the next window (all midscale) gives level=0.
REQ-032 Same stimulus with DECAY_EN=1 -> successive windows report 63, 62, 61, each with a single-cycle level_valid.
REQ-033 Sample 12'hFFF as the 8th (last) sample of a window -> included in that window, level=63.
REQ-034 Samples 12'h840 (mag 64 -> 2) and 12'h7C0 (mag 64 -> 2) interleaved with sample_valid gaps of 0-5 cycles -> exactly 8 accepted samples per pulse, level=2.
REQ-035 Assert rst for 1 cycle after 5 samples of 12'h000 -> no pulse, level=0, and the next pulse comes only after 8 further accepted samples.

Source files
------------

// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared widths and constants for the ADC level meter.
//   ADC_W    : raw ADC code width (unsigned, offset binary)
//   MAG_W    : magnitude width after saturation
//   LEVEL_W  : reported bar-graph level width
//   MIDSCALE : ADC code that represents zero signal
//   MAG_MAX  : saturation ceiling for the magnitude
// -----------------------------------------------------------------------------
package adc_pkg;

   localparam int ADC_W   = 12;
   localparam int MAG_W   = 11;
   localparam int LEVEL_W = 6;

   localparam logic [ADC_W-1:0] MIDSCALE = 12'h800;
   localparam logic [MAG_W-1:0] MAG_MAX  = 11'd2047;

   // The level is the top LEVEL_W bits of the magnitude (divide by 32).
   function automatic logic [LEVEL_W-1:0] mag_to_level(input logic [MAG_W-1:0] m);
      return m[MAG_W-1 -: LEVEL_W];
   endfunction

endpackage

// File: rtl/level_mag.sv
// -----------------------------------------------------------------------------
// level_mag
// Purely combinational: ADC code -> saturated magnitude |sample - MIDSCALE|.
// Ports:
//   sample : input  [ADC_W-1:0]  unsigned ADC code
//   mag    : output [MAG_W-1:0]  magnitude, 0..MAG_MAX
// -----------------------------------------------------------------------------
module level_mag
   import adc_pkg::*;
(
   input  logic [ADC_W-1:0] sample,
   output logic [MAG_W-1:0] mag
);

   logic signed [ADC_W-1:0] diff;
   logic        [ADC_W-1:0] abs_val;

   always_comb begin
      diff = sample - MIDSCALE;
      // Negating -2048 wraps back to 12'h800, which read unsigned is 2048:
      // the one value that needs the saturation below.
      abs_val = diff[ADC_W-1] ? $unsigned(-diff) : $unsigned(diff);
      mag     = abs_val[ADC_W-1] ? MAG_MAX : abs_val[MAG_W-1:0];
   end

endmodule

// File: rtl/level_meter.sv
// -----------------------------------------------------------------------------
// level_meter
// Windowed peak meter for a bar-graph display. Tracks the peak magnitude over
// 2^WIN_LOG2 accepted samples and reports its top 6 bits once per window,
// optionally with a release of at most one code per window.
// Parameters:
//   WIN_LOG2 : log2 of the window length in accepted samples
//   DECAY_EN : 1 = level falls by at most 1 code per window, 0 = raw peak
// Ports:
//   dclk         : input   clock, rising edge
//   rst          : input   synchronous active-high reset
//   sample_valid : input   one sample accepted per high cycle
//   sample       : input   [11:0] unsigned ADC code, 12'h800 = zero signal
//   level        : output  [5:0] registered window level
//   level_valid  : output  one-cycle pulse when level takes a new value
// Handshake: sample_valid has no back-pressure; every cycle it is high a
// sample is consumed. level_valid is a single-cycle strobe with no ready.
// -----------------------------------------------------------------------------
module level_meter
   import adc_pkg::*;
#(
   parameter int WIN_LOG2 = 9,
   parameter int DECAY_EN = 1
)(
   input  logic               dclk,
   input  logic               rst,
   input  logic               sample_valid,
   input  logic [ADC_W-1:0]   sample,
   output logic [LEVEL_W-1:0] level,
   output logic               level_valid
);

   logic [WIN_LOG2-1:0] cnt;
   logic [MAG_W-1:0]    peak;
   logic [MAG_W-1:0]    mag;
   logic [MAG_W-1:0]    peak_next;
   logic [LEVEL_W-1:0]  cand;
   logic [LEVEL_W-1:0]  level_dec;
   logic [LEVEL_W-1:0]  level_next;
   logic                last_sample;

   level_mag u_mag (
      .sample (sample),
      .mag    (mag)
   );

   always_comb begin
      // The current sample always takes part in the running peak, so the
      // last sample of a window is folded into the closing value.
      peak_next   = (mag > peak) ? mag : peak;
      cand        = mag_to_level(peak_next);
      level_dec   = (level == '0) ? '0 : level - LEVEL_W'(1);
      level_next  = cand;
      if (DECAY_EN != 0) begin
         level_next = (cand > level_dec) ? cand : level_dec;
      end
      last_sample = (cnt == {WIN_LOG2{1'b1}});
   end

   always_ff @(posedge dclk) begin
      if (rst) begin
         cnt         <= '0;
         peak        <= '0;
         level       <= '0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (sample_valid) begin
            if (last_sample) begin
               cnt         <= '0;
               peak        <= '0;
               level       <= level_next;
               level_valid <= 1'b1;
            end else begin
               cnt  <= cnt + WIN_LOG2'(1);
               peak <= peak_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_level_meter.sv
// -----------------------------------------------------------------------------
// tb_level_meter
// Three meters share one stimulus stream: window 8 without decay, window 8
// with decay, and the default configuration (window 512, decay on). A
// behavioural model keeps the history of accepted magnitudes and derives each
// meter's expected level from its window of that history.
// -----------------------------------------------------------------------------
module tb_level_meter;

   logic        dclk;
   logic        rst;
   logic        sample_valid;
   logic [11:0] sample;

   logic [5:0]  level0, level1, level2;
   logic        valid0, valid1, valid2;

   int n_total = 0;
   int n_bad   = 0;

   // ---------------- clock / reset block ----------------
   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   initial begin
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample       = 12'h800;
   end

   level_meter #(.WIN_LOG2(3), .DECAY_EN(0)) u_dut0 (
      .dclk(dclk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .level(level0), .level_valid(valid0));

   level_meter #(.WIN_LOG2(3), .DECAY_EN(1)) u_dut1 (
      .dclk(dclk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .level(level1), .level_valid(valid1));

   level_meter u_dut2 (
      .dclk(dclk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .level(level2), .level_valid(valid2));

   // ---------------- reference model ----------------
   int win_len[3]   = '{8, 8, 512};
   bit decay[3]     = '{1'b0, 1'b1, 1'b1};
   int start_idx[3] = '{0, 0, 0};
   int exp_level[3] = '{0, 0, 0};
   int exp_valid[3] = '{0, 0, 0};
   int hist[$];

   function automatic int ref_mag(input logic [11:0] s);
      int m;
      m = int'(s) - 2048;
      if (m < 0) m = -m;
      if (m > 2047) m = 2047;
      return m;
   endfunction

   task automatic model_update(input bit r, input bit v, input logic [11:0] s);
      int pk, cand, dec;
      if (r) begin
         hist.delete();
         for (int i = 0; i < 3; i++) begin
            start_idx[i] = 0;
            exp_level[i] = 0;
            exp_valid[i] = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) exp_valid[i] = 0;
         if (v) begin
            hist.push_back(ref_mag(s));
            for (int i = 0; i < 3; i++) begin
               if (hist.size() - start_idx[i] == win_len[i]) begin
                  pk = 0;
                  for (int k = start_idx[i]; k < hist.size(); k++)
                     if (hist[k] > pk) pk = hist[k];
                  cand = pk / 32;
                  if (decay[i]) begin
                     dec = (exp_level[i] > 0) ? exp_level[i] - 1 : 0;
                     exp_level[i] = (cand > dec) ? cand : dec;
                  end else begin
                     exp_level[i] = cand;
                  end
                  exp_valid[i] = 1;
                  start_idx[i] = hist.size();
               end
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic compare_all();
      check("level_w8_nodecay", int'(level0), exp_level[0]);
      check("valid_w8_nodecay", int'(valid0), exp_valid[0]);
      check("level_w8_decay",   int'(level1), exp_level[1]);
      check("valid_w8_decay",   int'(valid1), exp_valid[1]);
      check("level_default",    int'(level2), exp_level[2]);
      check("valid_default",    int'(valid2), exp_valid[2]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input bit r, input bit v, input logic [11:0] s);
      @(negedge dclk);
      rst          = r;
      sample_valid = v;
      sample       = s;
      @(posedge dclk);
      #1;
      model_update(r, v, s);
      compare_all();
   endtask

   task automatic feed(input logic [11:0] s);
      step(1'b0, 1'b1, s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'h800);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      bit r, v;
      logic [11:0] s;

      // Reset: a sample presented under reset must be discarded.
      step(1'b1, 1'b1, 12'h000);
      step(1'b1, 1'b0, 12'h800);
      check("rst_level0", int'(level0), 0);
      check("rst_valid0", int'(valid0), 0);
      check("rst_level1", int'(level1), 0);
      idle(2);

      // Midscale window: level 0, single pulse one cycle after the 8th sample.
      for (int i = 0; i < 7; i++) begin
         feed(12'h800);
         check("mid_no_early_pulse", int'(valid0), 0);
      end
      feed(12'h800);
      check("mid_pulse", int'(valid0), 1);
      check("mid_level", int'(level0), 0);
      idle(1);
      check("mid_pulse_one_cycle", int'(valid0), 0);

      // Full-scale negative sample, then two quiet windows.
      feed(12'h000);
      for (int i = 0; i < 7; i++) feed(12'h800);
      check("neg_full_nodecay", int'(level0), 63);
      check("neg_full_decay",   int'(level1), 63);
      for (int i = 0; i < 8; i++) feed(12'h800);
      check("quiet1_nodecay", int'(level0), 0);
      check("quiet1_decay",   int'(level1), 62);
      idle(1);
      check("quiet1_decay_hold", int'(level1), 62);
      check("quiet1_valid_low",  int'(valid1), 0);
      for (int i = 0; i < 8; i++) feed(12'h800);
      check("quiet2_decay", int'(level1), 61);
      check("quiet2_pulse", int'(valid1), 1);

      // Positive full scale as the last sample of the window.
      for (int i = 0; i < 7; i++) feed(12'h800);
      feed(12'hFFF);
      check("last_sample_nodecay", int'(level0), 63);
      check("last_sample_decay",   int'(level1), 63);

      // Small symmetric signal with random gaps.
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         idle($urandom_range(0, 5));
         feed((i % 2 == 0) ? 12'h840 : 12'h7C0);
         acc++;
         if (valid0) begin
            check("gap_count", acc, 8);
            check("gap_level", int'(level0), 2);
            acc = 0;
         end
      end
      check("gap_tail", acc, 0);

      // Reset mid-window discards the partial window.
      for (int i = 0; i < 5; i++) feed(12'h000);
      step(1'b1, 1'b0, 12'h800);
      check("midrst_level0", int'(level0), 0);
      check("midrst_valid0", int'(valid0), 0);
      for (int i = 0; i < 7; i++) begin
         feed(12'h800);
         check("midrst_no_pulse", int'(valid0), 0);
      end
      feed(12'h800);
      check("midrst_pulse", int'(valid0), 1);
      check("midrst_level", int'(level0), 0);

      // Random traffic, long enough to close several default-size windows.
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 999) == 0);
         v = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) == 0)
            s = 12'($urandom_range(0, 4095));
         else
            s = 12'(2048 + $urandom_range(0, 600) - 300);
         step(r, v, s);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
